// File: rtl/operand_fetch.sv
// Decode-side operand fetch: regfile read, writeback/bypass forwarding and a
// per-register pending-write scoreboard. Optional bypass: OPFETCH_BYPASS_EN.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic              in_use_rs,
  input  logic              in_use_rt,
  input  logic              in_wreg,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              re1,
  output logic              re2,
  output logic [ADDR_W-1:0] raddr_1,
  output logic [ADDR_W-1:0] raddr_2,
  input  logic [DATA_W-1:0] rdata_1,
  input  logic [DATA_W-1:0] rdata_2,
  input  logic              byp_valid,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic              out_wreg,
  output logic [ADDR_W-1:0] out_dest,
  output logic              hazard
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt   [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [DATA_W:0]   res1;
  logic [DATA_W:0]   res2;
  logic              sat;
  logic              accept;
  logic              kill;

`ifndef OPFETCH_BYPASS_EN
  logic byp_unused;
  assign byp_unused = ^{byp_valid, byp_addr, byp_data};
`endif

  // MSB of the result flags a resolved operand
  function automatic logic [DATA_W:0] resolve(
    input logic              used,
    input logic [ADDR_W-1:0] s,
    input logic [DATA_W-1:0] rd,
    input logic [CNT_W-1:0]  c
  );
    logic wb_hit;
    logic byp_hit;
    wb_hit = wb_we && (wb_waddr == s);
`ifdef OPFETCH_BYPASS_EN
    byp_hit = byp_valid && (byp_addr == s);
`else
    byp_hit = 1'b0;
`endif
    if (!used || s == '0)
      resolve = {1'b1, {DATA_W{1'b0}}};
    else if (c == '0)
      resolve = {1'b1, wb_hit ? wb_wdata : rd};
    else if (c == CNT_W'(1) && wb_hit)
      resolve = {1'b1, wb_wdata};
    else if (c == CNT_W'(1) && byp_hit)
      resolve = {1'b1, byp_data};
    else
      resolve = {1'b0, {DATA_W{1'b0}}};
  endfunction

  function automatic logic [CNT_W-1:0] step(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             dec_a,
    input logic             dec_b
  );
    logic [CNT_W:0] up;
    logic [CNT_W:0] dn;
    up = {1'b0, c} + {{CNT_W{1'b0}}, inc};
    dn = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
    step = (up < dn) ? '0 : CNT_W'(up - dn);
  endfunction

  assign re1     = in_valid && in_use_rs && !rst;
  assign re2     = in_valid && in_use_rt && !rst;
  assign raddr_1 = in_rs;
  assign raddr_2 = in_rt;

  assign res1 = resolve(in_use_rs, in_rs, rdata_1, cnt[in_rs]);
  assign res2 = resolve(in_use_rt, in_rt, rdata_2, cnt[in_rt]);
  assign sat  = in_wreg && (in_dest != '0) && (cnt[in_dest] == CNT_MAX);

  assign hazard   = in_valid && (!res1[DATA_W] || !res2[DATA_W] || sat);
  assign in_ready = !rst && !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign kill     = flush && out_valid && out_wreg;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = '0;
      if (r != 0)
        cnt_d[r] = step(cnt[r],
                        accept && in_wreg && (in_dest == ADDR_W'(r)),
                        wb_we && (wb_waddr == ADDR_W'(r)),
                        kill && (out_dest == ADDR_W'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_wreg  <= 1'b0;
      out_dest  <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_d[r];
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_op1   <= res1[DATA_W-1:0];
        out_op2   <= res2[DATA_W-1:0];
        out_wreg  <= in_wreg;
        out_dest  <= in_dest;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with an expected-output queue.
// Expectations follow the OPFETCH_BYPASS_EN setting of the build.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs = '0, in_rt = '0;
  logic        in_use_rs = 1'b0, in_use_rt = 1'b0;
  logic        in_wreg = 1'b0;
  logic [4:0]  in_dest = '0;
  logic        re1, re2;
  logic [4:0]  raddr_1, raddr_2;
  logic [31:0] rdata_1, rdata_2;
  logic        byp_valid = 1'b0;
  logic [4:0]  byp_addr = '0;
  logic [31:0] byp_data = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_op1, out_op2;
  logic        out_wreg;
  logic [4:0]  out_dest;
  logic        hazard;

  logic [31:0] rf [32];
  logic [69:0] q [$];
  int ncmp = 0;
  int nfail = 0;

  assign rdata_1 = rf[raddr_1];
  assign rdata_2 = rf[raddr_2];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt),
    .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .in_wreg(in_wreg), .in_dest(in_dest),
    .re1(re1), .re2(re2),
    .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_1(rdata_1), .rdata_2(rdata_2),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_wreg(out_wreg), .out_dest(out_dest),
    .hazard(hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic wreg, input logic [4:0] dest);
    in_valid  = 1'b1;
    in_rs     = rs;
    in_rt     = rt;
    in_use_rs = urs;
    in_use_rt = urt;
    in_wreg   = wreg;
    in_dest   = dest;
  endtask

  task automatic issue(input string tag,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic wreg, input logic [4:0] dest,
                       input logic [31:0] e1, input logic [31:0] e2);
    drv(rs, rt, urs, urt, wreg, dest);
    #1;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    q.push_back({e1, e2, wreg, dest});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we    = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        logic [69:0] e;
        e = q.pop_front();
        chk("sb_op1", out_op1, e[69:38]);
        chk("sb_op2", out_op2, e[37:6]);
        chk("sb_wreg", {31'd0, out_wreg}, {31'd0, e[5]});
        chk("sb_dest", {27'd0, out_dest}, {27'd0, e[4:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0F00_0000 | i;

    // reset
    drv(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_re1", {31'd0, re1}, 32'd0);
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_op1", out_op1, 32'd0);
    chk("rst_out_op2", out_op2, 32'd0);
    chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
    chk("rst_out_wreg", {31'd0, out_wreg}, 32'd0);

    // plain read
    rf[3] = 32'h1234;
    drv(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("rd_re1", {31'd0, re1}, 32'd1);
    chk("rd_raddr1", {27'd0, raddr_1}, 32'd3);
    issue("rd", 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1234, 32'd0);
    chk("rd_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_out_op1", out_op1, 32'h1234);

    // producer r5 then consumer
    issue("p5", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'd0);
    byp_valid = 1'b1; byp_addr = 5'd5; byp_data = 32'hAA;
    drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
`ifdef OPFETCH_BYPASS_EN
    chk("c5_hazard", {31'd0, hazard}, 32'd0);
    issue("c5", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hAA, 32'd0);
    byp_valid = 1'b0;
    wb(5'd5, 32'hBEEF);
    tick();
    wb_we = 1'b0;
`else
    chk("c5_hazard", {31'd0, hazard}, 32'd1);
    chk("c5_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("c5_hazard2", {31'd0, hazard}, 32'd1);
    wb(5'd5, 32'hBEEF);
    issue("c5", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hBEEF, 32'd0);
    wb_we = 1'b0;
    byp_valid = 1'b0;
`endif

    // two writers of r7
    issue("p7a", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'd0);
    issue("p7b", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'd0);
    byp_valid = 1'b1; byp_addr = 5'd7; byp_data = 32'h77;
    drv(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    chk("c7_hazard_cnt2", {31'd0, hazard}, 32'd1);
    tick();
    wb(5'd7, 32'h700);
    #1;
    chk("c7_hazard_wb_cnt2", {31'd0, hazard}, 32'd1);
    tick();
    wb_we = 1'b0;
`ifdef OPFETCH_BYPASS_EN
    issue("c7", 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'h77);
    byp_valid = 1'b0;
    wb(5'd7, 32'h701);
    tick();
    wb_we = 1'b0;
`else
    #1;
    chk("c7_hazard_cnt1", {31'd0, hazard}, 32'd1);
    wb(5'd7, 32'h701);
    issue("c7", 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'h701);
    wb_we = 1'b0;
    byp_valid = 1'b0;
`endif

    // saturate r9
    for (int i = 0; i < 3; i++)
      issue("p9", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 32'd0);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    #1;
    chk("sat_in_ready", {31'd0, in_ready}, 32'd0);
    chk("sat_hazard", {31'd0, hazard}, 32'd1);
    tick();
    chk("sat_in_ready2", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wb(5'd9, 32'h9);
    tick();
    wb_we = 1'b0;
    issue("p9d", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 32'd0);
    wb(5'd9, 32'h9);
    repeat (3) tick();
    wb_we = 1'b0;
    issue("p9chk", 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, rf[9], 32'd0);

    // register zero
    rf[0] = 32'hFFFF_FFFF;
    wb(5'd0, 32'hDEAD);
    issue("r0", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 32'd0, 32'd0);
    wb_we = 1'b0;
    issue("r0b", 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);

    // flush of a held writer of r4
    issue("p4a", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'd0);
    tick();
    out_ready = 1'b0;
    issue("p4b", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'd0);
    drv(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_dest", {27'd0, out_dest}, 32'd4);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    void'(q.pop_back());
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    drv(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("flush_cnt1_hazard", {31'd0, hazard}, 32'd1);
    wb(5'd4, 32'h4444);
    issue("c4", 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h4444, 32'd0);
    wb_we = 1'b0;

    // flush plus same-cycle retire on r4
    issue("p4c", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'd0);
    tick();
    out_ready = 1'b0;
    issue("p4d", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'd0);
    flush = 1'b1;
    wb(5'd4, 32'h4);
    void'(q.pop_back());
    tick();
    flush = 1'b0;
    wb_we = 1'b0;
    out_ready = 1'b1;
    rf[4] = 32'h4040;
    drv(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("flush2_hazard", {31'd0, hazard}, 32'd0);
    issue("c4b", 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h4040, 32'd0);

    // back-to-back issue
    for (int i = 0; i < 4; i++) begin
      rf[10 + i] = 32'hC000_0000 + 32'(i * 17);
      rf[11 + i] = 32'hD000_0000 + 32'(i * 29);
      issue("b2b", 5'(10 + i), 5'(11 + i), 1'b1, 1'b1, 1'b0, 5'd0,
            rf[10 + i], rf[11 + i]);
    end

    tick();
    tick();
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-side operand fetch for the 5-stage MIPS pipeline. Drives the register file read ports, applies writeback and result bypass, and gates issue with a per-register pending-write scoreboard. Holds decoded operands in a valid/ready output register feeding EX. It is the initiator of the register-file read interface and the consumer of its writeback stream.

## Interface
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width (32 registers)
- CNT_W, 2, scoreboard counter width per register (max 3 outstanding writes)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs, in_rt  in  ADDR_W  source registers
- in_use_rs, in_use_rt  in  1  source actually read
- in_wreg  in  1  instruction writes a register
- in_dest  in  ADDR_W  destination register
- re1, re2  out  1  regfile read enables
- raddr_1, raddr_2  out  ADDR_W  regfile read addresses
- rdata_1, rdata_2  in  DATA_W  regfile read data (same cycle)
- byp_valid  in  1  youngest in-flight result available (EX/MEM)
- byp_addr  in  ADDR_W;  byp_data  in  DATA_W
- wb_we  in  1  writeback commit;  wb_waddr  in  ADDR_W;  wb_wdata  in  DATA_W
- flush  in  1  kill held output instruction
- out_valid  out  1;  out_ready  in  1
- out_op1, out_op2  out  DATA_W  resolved operands
- out_wreg  out  1;  out_dest  out  ADDR_W
- hazard  out  1  in_valid held back by scoreboard (combinational)

## Operation
- re1 = in_valid && in_use_rs && !rst; raddr_1 = in_rs. re2/raddr_2 likewise for rt.
- Scoreboard: cnt[r], CNT_W bits, r = 1..31; cnt[0] hard 0. Register 0 never stalls, always reads 0.
- Operand resolution per source s (priority order):
  1. not used or s == 0 → 0.
  2. cnt[s] == 0 → rdata, except wb_we && wb_waddr == s → wb_wdata.
  3. cnt[s] == 1 && wb_we && wb_waddr == s → wb_wdata.
  4. cnt[s] == 1 && byp match (see Configuration) → byp_data.
  5. otherwise unresolved → hazard.
- Issue blocked if: any used source unresolved; or in_wreg && in_dest != 0 && cnt[in_dest] == 2^CNT_W-1 (saturation); or output slot occupied and not draining.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept: load out_op1/op2/wreg/dest, set out_valid; if in_wreg && in_dest != 0 then cnt[in_dest] += 1.
- Retire: wb_we && wb_waddr != 0 → cnt[wb_waddr] -= 1. Decrement at 0 is a protocol error (counter holds 0).
- Increment and decrement of the same register in one cycle → net unchanged.
- Flush: out_valid → 0 and, if held out_wreg && out_dest != 0, cnt[out_dest] -= 1; combines with same-cycle retire on that register (−2). No accept in a flush cycle.
- Downstream contract: every instruction handed over with out_valid && out_ready produces exactly one wb_we for its dest.

## Timing
- Reset: all cnt = 0, out_valid = 0, out_op1/op2 = 0, out_dest = 0, out_wreg = 0; in_ready = 0 and re1/re2 = 0 while rst high. Reset mid-operation discards held instruction and all pending counts.
- Latency: accept at edge N → out_valid high after edge N; one instruction per cycle sustained when out_ready held high.
- out_* stable while out_valid && !out_ready.
- Stalled instruction re-evaluated every cycle; resolves the cycle wb_we retires the last pending write.

## Configuration
- OPFETCH_BYPASS_EN defined: rule 4 active; byp match = byp_valid && byp_addr == s.
- Undefined: byp_* ignored; any cnt[s] != 0 not covered by rule 3 stalls until writeback (interlock-only pipeline).

## Test plan
- Reset then in rs=3 (cnt 0), rdata_1=0x1234 → next cycle out_valid=1, out_op1=0x1234, re1=1, raddr_1=3.
- Issue dest=5, then consumer rs=5 with byp_valid, byp_addr=5, byp_data=0xAA → with bypass: out_op1=0xAA, no stall; without: hazard=1 until wb_we 5, then out_op1=wb_wdata.
- Two writers to r7 (cnt=2), byp on r7 → stall; first wb retires (cnt=1) → bypass accepted.
- Three issues to r9 with no wb → fourth write to r9 held (in_ready=0) until one wb_we r9.
- rs=0, rt=0 with wb_we to r0 → operands 0, cnt unchanged, no stall.
- Held output dest=4 with out_ready=0, assert flush → out_valid=0, cnt[4] returns to prior value; same-cycle wb_we r4 → net −2.
